// File: rtl/multi_countdown_timer_pkg.sv
// multi_countdown_timer_pkg
// Shared types and constants for the multi-channel countdown timer.
//   state_t        : per-channel FSM state (IDLE, RUN, DONE)
//   MODE_REPEAT    : one_shot value selecting free-running repeat mode
//   MODE_ONE_SHOT  : one_shot value selecting single-pulse mode
//   psw_bits()     : width of the prescaler exponent field for a given
//                    prescaler counter width
package multi_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_REPEAT   = 1'b0;
  localparam logic MODE_ONE_SHOT = 1'b1;

  // Exponent field wide enough to select 0..prescaler_width-1; never zero width.
  function automatic int psw_bits(input int prescaler_width);
    return (prescaler_width > 1) ? $clog2(prescaler_width) : 1;
  endfunction

endpackage

// File: rtl/countdown_channel.sv
// countdown_channel
// One independent timer channel: emits a 1-cycle pulse every
// (duration + 2) << prescaler clocks, in repeat or one-shot mode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : level-sensitive enable; low forces IDLE on the next edge
//   one_shot        : mode, sampled only when the channel starts
//   prescaler       : prescaler exponent, sampled at start and at reload edges
//   duration        : duration, sampled at start and at reload edges
//   request_data    : combinational, high in the last cycle of a repeat period
//   pulse_out       : registered 1-cycle pulse at period end
//   busy            : registered, channel is counting
//   done            : registered, one-shot period has completed
module countdown_channel
  import multi_countdown_timer_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  parameter int PSW             = psw_bits(PRESCALER_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   one_shot,
  input  logic [PSW-1:0]         prescaler,
  input  logic [TIMER_WIDTH-1:0] duration,
  output logic                   request_data,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [PRESCALER_WIDTH:0] PRESC_ONE = {{PRESCALER_WIDTH{1'b0}}, 1'b1};
  localparam logic [TIMER_WIDTH:0]     DUR_ONE   = {{TIMER_WIDTH{1'b0}}, 1'b1};
  localparam logic [PRESCALER_WIDTH:0] PRESC_ZERO = '0;
  localparam logic [TIMER_WIDTH:0]     DUR_ZERO   = '0;

  state_t                   state;
  logic                     mode;
  logic [PRESCALER_WIDTH:0] presc_cnt;
  logic [PRESCALER_WIDTH:0] presc_max;
  logic [TIMER_WIDTH:0]     dur_cnt;
  logic [TIMER_WIDTH:0]     dur_max;
  logic                     presc_wrap;
  logic                     period_end;

  // Prescaler counts 0 .. 2^exp - 1, so one prescaler lap is 2^exp clocks.
  function automatic logic [PRESCALER_WIDTH:0] presc_limit(input logic [PSW-1:0] exp_val);
    return (PRESC_ONE << exp_val) - PRESC_ONE;
  endfunction

  // Duration counts 0 .. duration + 1 laps, giving (duration + 2) laps per period.
  function automatic logic [TIMER_WIDTH:0] dur_limit(input logic [TIMER_WIDTH-1:0] dur_val);
    return {1'b0, dur_val} + DUR_ONE;
  endfunction

  // The counters hold the number of clocks elapsed since the period began;
  // they reach their limits together exactly one cycle before the pulse edge,
  // which is also the cycle in which the next period's settings are requested.
  assign presc_wrap   = (presc_cnt == presc_max);
  assign period_end   = presc_wrap && (dur_cnt == dur_max);
  assign request_data = en && (state == RUN) && (mode == MODE_REPEAT) && period_end;

  // Channel FSM, counters and registered outputs. A low enable overrides
  // everything, including a coinciding period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= MODE_REPEAT;
      presc_cnt <= PRESC_ZERO;
      presc_max <= PRESC_ZERO;
      dur_cnt   <= DUR_ZERO;
      dur_max   <= DUR_ZERO;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        presc_cnt <= PRESC_ZERO;
        dur_cnt   <= DUR_ZERO;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            mode      <= one_shot;
            presc_max <= presc_limit(prescaler);
            dur_max   <= dur_limit(duration);
            presc_cnt <= PRESC_ZERO;
            dur_cnt   <= DUR_ZERO;
            busy      <= 1'b1;
            state     <= RUN;
          end
          RUN: begin
            if (period_end) begin
              pulse_out <= 1'b1;
              presc_cnt <= PRESC_ZERO;
              dur_cnt   <= DUR_ZERO;
              if (mode == MODE_ONE_SHOT) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                presc_max <= presc_limit(prescaler);
                dur_max   <= dur_limit(duration);
              end
            end else if (presc_wrap) begin
              presc_cnt <= PRESC_ZERO;
              dur_cnt   <= dur_cnt + DUR_ONE;
            end else begin
              presc_cnt <= presc_cnt + PRESC_ONE;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_countdown_timer.sv
// multi_countdown_timer
// NUM_CHANNELS independent countdown timers sharing only clock and reset.
// Ports:
//   clk           : system clock
//   sys_rst_n     : asynchronous active-low reset (released synchronously upstream)
//   en            : per-channel enable
//   one_shot      : per-channel mode (0 repeat, 1 one-shot)
//   prescaler     : flattened exponents, channel i at [i*PSW +: PSW]
//   duration      : flattened durations, channel i at [i*TIMER_WIDTH +: TIMER_WIDTH]
//   request_data  : per-channel reload request (combinational)
//   pulse_out     : per-channel period-end pulse
//   busy          : per-channel running status
//   done          : per-channel one-shot finished status
module multi_countdown_timer
  import multi_countdown_timer_pkg::*;
#(
  parameter  int NUM_CHANNELS    = 2,
  parameter  int PRESCALER_WIDTH = 16,
  parameter  int TIMER_WIDTH     = 8,
  localparam int PSW             = psw_bits(PRESCALER_WIDTH)
) (
  input  logic                              clk,
  input  logic                              sys_rst_n,
  input  logic [NUM_CHANNELS-1:0]           en,
  input  logic [NUM_CHANNELS-1:0]           one_shot,
  input  logic [NUM_CHANNELS*PSW-1:0]       prescaler,
  input  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] duration,
  output logic [NUM_CHANNELS-1:0]           request_data,
  output logic [NUM_CHANNELS-1:0]           pulse_out,
  output logic [NUM_CHANNELS-1:0]           busy,
  output logic [NUM_CHANNELS-1:0]           done
);

  // One channel per stream; each takes its own slice of the flattened buses.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    countdown_channel #(
      .PRESCALER_WIDTH(PRESCALER_WIDTH),
      .TIMER_WIDTH    (TIMER_WIDTH),
      .PSW            (PSW)
    ) u_channel (
      .clk         (clk),
      .rst_n       (sys_rst_n),
      .en          (en[i]),
      .one_shot    (one_shot[i]),
      .prescaler   (prescaler[i*PSW +: PSW]),
      .duration    (duration[i*TIMER_WIDTH +: TIMER_WIDTH]),
      .request_data(request_data[i]),
      .pulse_out   (pulse_out[i]),
      .busy        (busy[i]),
      .done        (done[i])
    );
  end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// tb_multi_countdown_timer
// Self-checking bench for multi_countdown_timer. A reference model tracks,
// per channel, whether it is idle, running or done and the absolute edge
// number of its next pulse; DUT outputs are compared every cycle, and
// directed scenarios additionally check pulse spacing against fixed values.
module tb_multi_countdown_timer;

  localparam int NCH = 2;
  localparam int PW  = 16;
  localparam int TW  = 8;
  localparam int PSW = $clog2(PW);

  logic                clk = 1'b0;
  logic                sys_rst_n;
  logic [NCH-1:0]      en;
  logic [NCH-1:0]      one_shot;
  logic [NCH*PSW-1:0]  prescaler;
  logic [NCH*TW-1:0]   duration;
  logic [NCH-1:0]      request_data;
  logic [NCH-1:0]      pulse_out;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      done;

  multi_countdown_timer #(
    .NUM_CHANNELS   (NCH),
    .PRESCALER_WIDTH(PW),
    .TIMER_WIDTH    (TW)
  ) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .one_shot    (one_shot),
    .prescaler   (prescaler),
    .duration    (duration),
    .request_data(request_data),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;
  int edge_cnt    = 0;

  // Model: 0 idle, 1 running, 2 done; deadline is the edge number of the next pulse.
  int             m_state    [NCH];
  int             m_deadline [NCH];
  bit             m_one_shot [NCH];
  logic [NCH-1:0] exp_pulse;
  logic [NCH-1:0] exp_busy;
  logic [NCH-1:0] exp_done;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (edge %0d)", tag, actual, expected, edge_cnt);
    end
  endtask

  function automatic int period_of(input int ch);
    int d;
    int p;
    d = int'(duration[ch*TW +: TW]);
    p = int'(prescaler[ch*PSW +: PSW]);
    return (d + 2) << p;
  endfunction

  function automatic logic [NCH-1:0] exp_request();
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++)
      r[i] = en[i] && (m_state[i] == 1) && !m_one_shot[i] && (m_deadline[i] == edge_cnt + 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_state[i]    = 0;
      m_deadline[i] = 0;
      m_one_shot[i] = 1'b0;
    end
    exp_pulse = '0;
    exp_busy  = '0;
    exp_done  = '0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    edge_cnt++;
    for (int i = 0; i < NCH; i++) begin
      exp_pulse[i] = 1'b0;
      if (!en[i]) begin
        m_state[i]  = 0;
        exp_busy[i] = 1'b0;
        exp_done[i] = 1'b0;
      end else if (m_state[i] == 0) begin
        m_state[i]    = 1;
        m_one_shot[i] = one_shot[i];
        m_deadline[i] = edge_cnt + period_of(i);
        exp_busy[i]   = 1'b1;
      end else if (m_state[i] == 1 && m_deadline[i] == edge_cnt) begin
        exp_pulse[i] = 1'b1;
        if (m_one_shot[i]) begin
          m_state[i]  = 2;
          exp_busy[i] = 1'b0;
          exp_done[i] = 1'b1;
        end else begin
          m_deadline[i] = edge_cnt + period_of(i);
        end
      end
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NCH; i++) begin
      if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
      if ($urandom_range(0, 7) == 0) one_shot[i] = ~one_shot[i];
      if ($urandom_range(0, 3) == 0) begin
        prescaler[i*PSW +: PSW] = PSW'($urandom_range(0, 2));
        duration[i*TW +: TW]    = TW'($urandom_range(0, 12));
      end
    end
  endtask

  // Called at a falling edge; each cycle compares all outputs, then steps the model.
  task automatic run_cycles(input int n, input bit random_inputs);
    for (int k = 0; k < n; k++) begin
      if (random_inputs) applyStimulus();
      #1;
      checkOutput("pulse_out", 32'(pulse_out), 32'(exp_pulse));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done", 32'(done), 32'(exp_done));
      checkOutput("request_data", 32'(request_data), 32'(exp_request()));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  // Run until channel ch pulses; gives -1 if the bound expires.
  task automatic wait_pulse(input int ch, output int at_edge);
    at_edge = -1;
    for (int k = 0; k < 400; k++) begin
      run_cycles(1, 1'b0);
      if (pulse_out[ch] === 1'b1) begin
        at_edge = edge_cnt;
        break;
      end
    end
  endtask

  task automatic set_channel(input int ch, input bit e, input bit os, input int d, input int p);
    en[ch]                   = e;
    one_shot[ch]             = os;
    duration[ch*TW +: TW]    = TW'(d);
    prescaler[ch*PSW +: PSW] = PSW'(p);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start_edge;
    int e1;
    int e2;
    int e3;

    sys_rst_n = 1'b0;
    en        = '0;
    one_shot  = '0;
    prescaler = '0;
    duration  = '0;
    model_reset();
    #12;
    checkOutput("reset_pulse", 32'(pulse_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_request", 32'(request_data), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    run_cycles(2, 1'b0);

    // Minimum period: pulse every 2 cycles, request every other cycle.
    $display("[TB] minimum period");
    set_channel(0, 1'b1, 1'b0, 0, 0);
    start_edge = edge_cnt + 1;
    wait_pulse(0, e1);
    checkOutput("min_first_pulse", 32'(e1 - start_edge), 32'd2);
    run_cycles(10, 1'b0);
    en[0] = 1'b0;
    run_cycles(3, 1'b0);

    // Reload sampled at period end: 20 then 3-cycle periods.
    $display("[TB] repeat reload");
    set_channel(0, 1'b1, 1'b0, 3, 2);
    start_edge = edge_cnt + 1;
    run_cycles(5, 1'b0);
    set_channel(0, 1'b1, 1'b0, 1, 0);
    wait_pulse(0, e1);
    checkOutput("reload_first", 32'(e1 - start_edge), 32'd20);
    wait_pulse(0, e2);
    checkOutput("reload_second", 32'(e2 - e1), 32'd3);
    wait_pulse(0, e3);
    checkOutput("reload_third", 32'(e3 - e2), 32'd3);
    en[0] = 1'b0;
    run_cycles(3, 1'b0);

    // One-shot: single pulse, done held, restart after en toggle.
    $display("[TB] one-shot");
    set_channel(1, 1'b1, 1'b1, 1, 1);
    start_edge = edge_cnt + 1;
    wait_pulse(1, e1);
    checkOutput("oneshot_pulse", 32'(e1 - start_edge), 32'd6);
    checkOutput("oneshot_done", 32'(done[1]), 32'd1);
    checkOutput("oneshot_busy", 32'(busy[1]), 32'd0);
    run_cycles(50, 1'b0);
    en[1] = 1'b0;
    run_cycles(2, 1'b0);
    en[1] = 1'b1;
    start_edge = edge_cnt + 1;
    wait_pulse(1, e1);
    checkOutput("oneshot_restart", 32'(e1 - start_edge), 32'd6);
    en[1] = 1'b0;
    run_cycles(3, 1'b0);

    // Two channels in parallel, then ch0 disabled while ch1 keeps running.
    $display("[TB] two channels");
    set_channel(0, 1'b1, 1'b0, 2, 0);
    set_channel(1, 1'b1, 1'b0, 5, 1);
    run_cycles(60, 1'b0);
    en[0] = 1'b0;
    run_cycles(40, 1'b0);
    en[1] = 1'b0;
    run_cycles(3, 1'b0);

    // Disable exactly at the pulse edge suppresses the pulse.
    $display("[TB] disable at period end");
    set_channel(0, 1'b1, 1'b0, 4, 0);
    run_cycles(6, 1'b0);
    en[0] = 1'b0;
    run_cycles(1, 1'b0);
    checkOutput("disable_no_pulse", 32'(pulse_out[0]), 32'd0);
    checkOutput("disable_busy", 32'(busy[0]), 32'd0);
    run_cycles(3, 1'b0);

    // Largest duration at prescaler 0.
    $display("[TB] max duration");
    set_channel(0, 1'b1, 1'b0, 255, 0);
    start_edge = edge_cnt + 1;
    wait_pulse(0, e1);
    checkOutput("max_duration", 32'(e1 - start_edge), 32'd257);
    en[0] = 1'b0;
    run_cycles(3, 1'b0);

    // Asynchronous reset mid-period, then a fresh start after release.
    $display("[TB] async reset");
    set_channel(0, 1'b1, 1'b0, 3, 1);
    run_cycles(4, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_pulse", 32'(pulse_out), 32'd0);
    checkOutput("async_request", 32'(request_data), 32'd0);
    model_reset();
    @(negedge clk);
    sys_rst_n = 1'b1;
    start_edge = edge_cnt + 1;
    wait_pulse(0, e1);
    checkOutput("post_reset_pulse", 32'(e1 - start_edge), 32'd10);

    // Randomized traffic on all channels.
    $display("[TB] random traffic");
    en       = '1;
    one_shot = '0;
    run_cycles(3000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
